countdown_timer: RTL and testbench
==================================

Name: countdown_timer

Overview:
- Loadable down-counter/timer; consumer-side counterpart of the team's loadable up-counter.
- Loads a start value, decrements on enabled cycles and signals terminal count.
- Runs either one-shot or periodic with auto-reload.
- Used by control logic to time delays and intervals; drives a one-cycle done pulse and status flags.

Parameters:
- WIDTH, 5, bit width of the count value and the load value (max count 2^WIDTH-1).

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  reset; one clock, asynchronous, active-high
- clr  input  1  synchronous clear to idle
- cnt_in  input  WIDTH  start/reload value, captured on load
- load  input  1  synchronous load strobe
- enab  input  1  count enable; decrement only when high
- auto_reload  input  1  1 = periodic, 0 = one-shot
- cnt_out  output  WIDTH  current count, registered
- done  output  1  one-cycle pulse on terminal count, registered
- busy  output  1  high while in RUN
- expired  output  1  high while in EXPIRED (one-shot finished)
- zero  output  1  cnt_out == 0 (combinational decode)

Behaviour:
- Registers: cnt_out, reload_val (WIDTH bits), state, done.
- FSM states: IDLE, RUN, EXPIRED. busy = (state==RUN). expired = (state==EXPIRED). Both are decodes of the state register.
- Reset (rst=1, async, any time including mid-count):
  - state=IDLE, cnt_out=0, reload_val=0, done=0.
  - Hence busy=0, expired=0, zero=1.
- Per-edge priority: rst > clr > load > count. done defaults to 0 every cycle unless set by the terminal rule.
- clr: state=IDLE, cnt_out=0; reload_val unchanged; done=0.
- load (any state, clr low):
  - cnt_out=cnt_in, reload_val=cnt_in.
  - state=RUN if cnt_in!=0, else IDLE.
  - enab ignored that cycle. No done pulse, even if a terminal would otherwise occur.
- IDLE: cnt_out holds; enab ignored.
- RUN, enab=0: hold count and state.
- RUN, enab=1, cnt_out>1: cnt_out=cnt_out-1.
- RUN, enab=1, cnt_out==1 (terminal):
  - done=1 next cycle, for exactly one cycle.
  - auto_reload=1: cnt_out=reload_val, stay RUN.
  - auto_reload=0: cnt_out=0, state=EXPIRED.
  - auto_reload is sampled only on the terminal cycle.
- Timing: load value N (N>=1), with enab held high from the cycle after load:
  - done asserts N cycles after the load edge.
  - Periodic mode: done repeats every N enabled cycles.
  - N=1 periodic: done high every enabled cycle.
- EXPIRED: cnt_out=0 holds; enab ignored; exits only via load, clr or rst.
- No wrap-around: the counter never decrements below 0 and never underflows from 0 to 2^WIDTH-1.
- Arithmetic is WIDTH-bit unsigned. The terminal compare is against 1.
- Next-state/next-count logic is implemented as a function called from the clocked process, with arguments in declaration order.

Test Plan:
- Reset mid-count: load 10, enab=1 for 3 cycles, pulse rst between edges -> immediately cnt_out=0, busy=0, zero=1, done=0; no further counting.
- One-shot: auto_reload=0, load 5, enab=1 continuously:
  - cnt_out goes 5,4,3,2,1,0.
  - done high one cycle, coinciding with cnt_out=0.
  - expired=1 and busy=0 thereafter.
  - Further enab does not change cnt_out.
- Periodic with gaps: auto_reload=1, load 3, enab toggled 1,0,1,1,0,1,1,1:
  - Count holds on enab=0 cycles.
  - done pulses after the 3rd and 6th enabled cycles.
  - cnt_out reloads to 3 each time; busy stays 1.
- Load of zero and N=1:
  - load 0 -> state IDLE, zero=1, no done.
  - load 1 with auto_reload=1, enab=1 -> done high every cycle after load, cnt_out stays 1.
- Collisions:
  - At cnt_out=1 with enab=1, assert load with cnt_in=7 -> cnt_out=7, done stays 0.
  - Assert clr together with load -> IDLE, cnt_out=0.
- Width boundary: WIDTH=5, load 31, enab=1, auto_reload=0 -> done exactly 31 cycles after the load edge; no underflow to 31 after reaching 0.

Source files
------------

// File: rtl/countdown_timer.sv
// Loadable down-counter with one-shot or periodic auto-reload operation.
// Drives a registered one-cycle done pulse on terminal count plus state flags.
module countdown_timer #(
  parameter int WIDTH = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic [WIDTH-1:0] cnt_in,
  input  logic             load,
  input  logic             enab,
  input  logic             auto_reload,
  output logic [WIDTH-1:0] cnt_out,
  output logic             done,
  output logic             busy,
  output logic             expired,
  output logic             zero
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    EXPIRED = 2'd2
  } state_t;

  typedef struct packed {
    state_t           state;
    logic [WIDTH-1:0] cnt;
    logic [WIDTH-1:0] reload;
    logic             done;
  } step_t;

  localparam logic [WIDTH-1:0] CNT_ZERO = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] CNT_ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

  state_t           state;
  logic [WIDTH-1:0] reload_val;

  // Next state/count/reload/done for one edge; priority clr > load > count.
  function automatic step_t step_fn(
    input state_t           st,
    input logic [WIDTH-1:0] cnt,
    input logic [WIDTH-1:0] rld,
    input logic             clr_in,
    input logic [WIDTH-1:0] din,
    input logic             ld,
    input logic             en,
    input logic             ar
  );
    step_t r;
    r.state  = st;
    r.cnt    = cnt;
    r.reload = rld;
    r.done   = 1'b0;
    if (clr_in) begin
      r.state = IDLE;
      r.cnt   = CNT_ZERO;
    end else if (ld) begin
      r.cnt    = din;
      r.reload = din;
      r.state  = (din != CNT_ZERO) ? RUN : IDLE;
    end else begin
      case (st)
        IDLE: begin
          r.state = IDLE;
        end
        RUN: begin
          if (en) begin
            if (cnt == CNT_ONE) begin
              r.done = 1'b1;
              // auto_reload only matters on the terminal cycle
              if (ar) begin
                r.cnt = rld;
              end else begin
                r.cnt   = CNT_ZERO;
                r.state = EXPIRED;
              end
            end else if (cnt > CNT_ONE) begin
              r.cnt = cnt - CNT_ONE;
            end else begin
              r.cnt = CNT_ZERO;
            end
          end else begin
            r.cnt = cnt;
          end
        end
        EXPIRED: begin
          r.cnt = CNT_ZERO;
        end
        default: begin
          r.state = IDLE;
          r.cnt   = CNT_ZERO;
        end
      endcase
    end
    return r;
  endfunction

  // State, count, reload value and done pulse registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cnt_out    <= CNT_ZERO;
      reload_val <= CNT_ZERO;
      done       <= 1'b0;
    end else begin
      {state, cnt_out, reload_val, done} <= step_fn(state, cnt_out, reload_val,
                                                    clr, cnt_in, load, enab,
                                                    auto_reload);
    end
  end

  assign busy    = (state == RUN);
  assign expired = (state == EXPIRED);
  assign zero    = (cnt_out == CNT_ZERO);

endmodule

// File: tb/tb_countdown_timer.sv
// Directed table-driven bench for countdown_timer plus hand-written
// sequences for asynchronous reset mid-count and the full-width count.
module tb_countdown_timer;

  localparam int WIDTH = 5;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             clr = 1'b0;
  logic             load = 1'b0;
  logic             enab = 1'b0;
  logic             auto_reload = 1'b0;
  logic [WIDTH-1:0] cnt_in = 5'd0;
  logic [WIDTH-1:0] cnt_out;
  logic             done;
  logic             busy;
  logic             expired;
  logic             zero;

  int total = 0;
  int bad   = 0;

  countdown_timer #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst(rst), .clr(clr), .cnt_in(cnt_in), .load(load),
    .enab(enab), .auto_reload(auto_reload), .cnt_out(cnt_out),
    .done(done), .busy(busy), .expired(expired), .zero(zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic             c;
    logic             l;
    logic [WIDTH-1:0] din;
    logic             e;
    logic             ar;
    logic [WIDTH-1:0] x_cnt;
    logic             x_done;
    logic             x_busy;
    logic             x_exp;
    logic             x_zero;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic c, input logic l, input int din,
                              input logic e, input logic ar, input int xc,
                              input logic xd, input logic xb, input logic xe);
    vec_t v;
    v.c      = c;
    v.l      = l;
    v.din    = WIDTH'(din);
    v.e      = e;
    v.ar     = ar;
    v.x_cnt  = WIDTH'(xc);
    v.x_done = xd;
    v.x_busy = xb;
    v.x_exp  = xe;
    v.x_zero = (xc == 0);
    return v;
  endfunction

  task automatic check(input string name, input logic [WIDTH-1:0] xc,
                       input logic xd, input logic xb, input logic xe,
                       input logic xz);
    total++;
    if ({cnt_out, done, busy, expired, zero} !== {xc, xd, xb, xe, xz}) begin
      bad++;
      $display("FAIL %s: got cnt=%0d done=%b busy=%b expired=%b zero=%b, expected cnt=%0d done=%b busy=%b expired=%b zero=%b",
               name, cnt_out, done, busy, expired, zero, xc, xd, xb, xe, xz);
    end
  endtask

  task automatic drive(input logic c, input logic l, input logic [WIDTH-1:0] din,
                       input logic e, input logic ar);
    @(negedge clk);
    clr = c; load = l; cnt_in = din; enab = e; auto_reload = ar;
    @(posedge clk);
    #1;
  endtask

  initial begin
    //          clr ld din en ar  cnt dn bs ex
    // one-shot load 5, runs to EXPIRED, further enab ignored
    vecs.push_back(mk(0, 1, 5, 0, 0, 5, 0, 1, 0));
    vecs.push_back(mk(0, 0, 0, 1, 0, 4, 0, 1, 0));
    vecs.push_back(mk(0, 0, 0, 1, 0, 3, 0, 1, 0));
    vecs.push_back(mk(0, 0, 0, 1, 0, 2, 0, 1, 0));
    vecs.push_back(mk(0, 0, 0, 1, 0, 1, 0, 1, 0));
    vecs.push_back(mk(0, 0, 0, 1, 0, 0, 1, 0, 1));
    vecs.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0, 1));
    vecs.push_back(mk(0, 0, 0, 1, 1, 0, 0, 0, 1));
    // periodic load 3 from EXPIRED, enab 1,0,1,1,0,1,1,1
    vecs.push_back(mk(0, 1, 3, 0, 1, 3, 0, 1, 0));
    vecs.push_back(mk(0, 0, 0, 1, 1, 2, 0, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0, 1, 2, 0, 1, 0));
    vecs.push_back(mk(0, 0, 0, 1, 1, 1, 0, 1, 0));
    vecs.push_back(mk(0, 0, 0, 1, 1, 3, 1, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0, 1, 3, 0, 1, 0));
    vecs.push_back(mk(0, 0, 0, 1, 1, 2, 0, 1, 0));
    vecs.push_back(mk(0, 0, 0, 1, 1, 1, 0, 1, 0));
    vecs.push_back(mk(0, 0, 0, 1, 1, 3, 1, 1, 0));
    // load zero -> IDLE, no done
    vecs.push_back(mk(0, 1, 0, 1, 1, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 1, 1, 0, 0, 0, 0));
    // N=1 periodic: done every enabled cycle
    vecs.push_back(mk(0, 1, 1, 1, 1, 1, 0, 1, 0));
    vecs.push_back(mk(0, 0, 0, 1, 1, 1, 1, 1, 0));
    vecs.push_back(mk(0, 0, 0, 1, 1, 1, 1, 1, 0));
    vecs.push_back(mk(0, 0, 0, 1, 1, 1, 1, 1, 0));
    // load at terminal cycle wins, no done
    vecs.push_back(mk(0, 1, 7, 1, 1, 7, 0, 1, 0));
    vecs.push_back(mk(0, 0, 0, 1, 1, 6, 0, 1, 0));
    // clr beats load
    vecs.push_back(mk(1, 1, 9, 1, 1, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 1, 1, 0, 0, 0, 0));
    // clr in RUN
    vecs.push_back(mk(0, 1, 4, 0, 0, 4, 0, 1, 0));
    vecs.push_back(mk(1, 0, 0, 1, 0, 0, 0, 0, 0));
    // auto_reload sampled only at terminal
    vecs.push_back(mk(0, 1, 2, 0, 0, 2, 0, 1, 0));
    vecs.push_back(mk(0, 0, 0, 1, 0, 1, 0, 1, 0));
    vecs.push_back(mk(0, 0, 0, 1, 1, 2, 1, 1, 0));
    vecs.push_back(mk(0, 0, 0, 1, 0, 1, 0, 1, 0));
    vecs.push_back(mk(0, 0, 0, 1, 0, 0, 1, 0, 1));

    #2;
    check("reset_state", 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].c, vecs[i].l, vecs[i].din, vecs[i].e, vecs[i].ar);
      check($sformatf("vec%0d", i), vecs[i].x_cnt, vecs[i].x_done,
            vecs[i].x_busy, vecs[i].x_exp, vecs[i].x_zero);
    end

    // async reset mid-count: load 10, three enabled cycles, then rst between edges
    drive(1'b0, 1'b1, 5'd10, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) drive(1'b0, 1'b0, 5'd0, 1'b1, 1'b0);
    check("pre_reset_count", 5'd7, 1'b0, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("async_reset", 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 3; i++) drive(1'b0, 1'b0, 5'd0, 1'b1, 1'b0);
    check("post_reset_hold", 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);

    // width boundary: load 31 one-shot, done exactly 31 edges after load
    begin
      int edges;
      int done_at;
      done_at = -1;
      drive(1'b0, 1'b1, 5'd31, 1'b0, 1'b0);
      check("load31", 5'd31, 1'b0, 1'b1, 1'b0, 1'b0);
      for (edges = 1; edges <= 40 && done_at < 0; edges++) begin
        drive(1'b0, 1'b0, 5'd0, 1'b1, 1'b0);
        if (done) done_at = edges;
      end
      total++;
      if (done_at != 31) begin
        bad++;
        $display("FAIL done_latency_31: got %0d edges, expected 31", done_at);
      end
      check("terminal31", 5'd0, 1'b1, 1'b0, 1'b1, 1'b1);
      for (int i = 0; i < 3; i++) drive(1'b0, 1'b0, 5'd0, 1'b1, 1'b0);
      check("no_underflow", 5'd0, 1'b0, 1'b0, 1'b1, 1'b1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
